// File: rtl/rob_tracker.sv
// Reorder buffer: allocates N entries per cycle in program order, marks them complete from N
// completion lanes, and retires up to N oldest completed entries. A retiring mispredict flushes everything.

module rob_retire_lane (
  input  logic prev_ok_i,
  input  logic prev_mp_i,
  input  logic vld_i,
  input  logic cmp_i,
  output logic ret_o
);
  // A lane retires only if every older lane retires and none of them redirects.
  assign ret_o = prev_ok_i & ~prev_mp_i & vld_i & cmp_i;
endmodule

module rob_tracker #(
  parameter int N      = 3,
  parameter int ROB_SZ = 32,
  parameter int IDXW   = $clog2(ROB_SZ),
  parameter int PRW    = 6,
  parameter int XLEN   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N-1:0]              disp_valid_i,
  input  logic [N-1:0][XLEN-1:0]    disp_pc_i,
  input  logic [N-1:0][4:0]         disp_arch_rd_i,
  input  logic [N-1:0][PRW-1:0]     disp_phys_rd_i,
  output logic [N-1:0][IDXW-1:0]    disp_rob_idx_o,
  output logic                      disp_stall_o,
  output logic [IDXW:0]             free_slots_o,
  input  logic [N-1:0]              cmp_valid_i,
  input  logic [N-1:0][IDXW-1:0]    cmp_idx_i,
  input  logic [N-1:0]              cmp_mispredict_i,
  input  logic [N-1:0]              cmp_branch_taken_i,
  input  logic [N-1:0][XLEN-1:0]    cmp_branch_target_i,
  output logic [N-1:0]              retire_valid_o,
  output logic [N-1:0][4:0]         retire_arch_rd_o,
  output logic [N-1:0][PRW-1:0]     retire_phys_rd_o,
  output logic [N-1:0][XLEN-1:0]    retire_pc_o,
  output logic                      flush_valid_o,
  output logic [XLEN-1:0]           flush_target_o
);

  typedef struct packed {
    logic            vld;
    logic            cmp;
    logic            mp;
    logic            tkn;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc;
    logic [4:0]      ard;
    logic [PRW-1:0]  prd;
  } rob_ent_t;

  rob_ent_t               ent_q [ROB_SZ];
  rob_ent_t               ent_d [ROB_SZ];
  logic [IDXW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [IDXW:0]          count_q, count_d;
  logic [IDXW:0]          k, r;
  logic [IDXW-1:0]        off;
  logic [N-1:0][IDXW-1:0] ridx;
  logic [N-1:0]           prev_mp;
  logic [N:0]             ok_chain;

  assign ok_chain[0]    = 1'b1;
  assign retire_valid_o = ok_chain[N:1];
  assign free_slots_o   = (IDXW+1)'(ROB_SZ) - count_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign ridx[i] = head_q + IDXW'(i);
    if (i == 0) begin : g_first
      assign prev_mp[i] = 1'b0;
    end else begin : g_rest
      assign prev_mp[i] = ent_q[ridx[i-1]].mp;
    end
    rob_retire_lane u_ret (
      .prev_ok_i (ok_chain[i]),
      .prev_mp_i (prev_mp[i]),
      .vld_i     (ent_q[ridx[i]].vld),
      .cmp_i     (ent_q[ridx[i]].cmp),
      .ret_o     (ok_chain[i+1])
    );
    assign retire_arch_rd_o[i] = ent_q[ridx[i]].ard;
    assign retire_phys_rd_o[i] = ent_q[ridx[i]].prd;
    assign retire_pc_o[i]      = ent_q[ridx[i]].pc;
  end

  always_comb begin
    flush_valid_o  = 1'b0;
    flush_target_o = '0;
    r              = '0;
    for (int i = 0; i < N; i++) begin
      r = r + (IDXW+1)'(retire_valid_o[i]);
      // Retire chain stops after a mispredict, so at most one lane hits this.
      if (retire_valid_o[i] && ent_q[ridx[i]].mp) begin
        flush_valid_o  = 1'b1;
        flush_target_o = ent_q[ridx[i]].tkn ? ent_q[ridx[i]].tgt : ent_q[ridx[i]].pc + XLEN'(4);
      end
    end
  end

  always_comb begin
    k   = '0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      k                 = k + (IDXW+1)'(disp_valid_i[i]);
      disp_rob_idx_o[i] = '0;
      if (disp_valid_i[i]) begin
        disp_rob_idx_o[i] = tail_q + off;
        off               = off + IDXW'(1);
      end
    end
    // Freed slots from this cycle's retirements are not credited.
    disp_stall_o = flush_valid_o || (k > free_slots_o);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_valid_o) begin
      for (int e = 0; e < ROB_SZ; e++) begin
        ent_d[e].vld = 1'b0;
        ent_d[e].cmp = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Ascending lane order lets the highest lane win on duplicate indices.
      for (int i = 0; i < N; i++) begin
        if (cmp_valid_i[i] && ent_q[cmp_idx_i[i]].vld) begin
          ent_d[cmp_idx_i[i]].cmp = 1'b1;
          ent_d[cmp_idx_i[i]].mp  = cmp_mispredict_i[i];
          ent_d[cmp_idx_i[i]].tkn = cmp_branch_taken_i[i];
          ent_d[cmp_idx_i[i]].tgt = cmp_branch_target_i[i];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (retire_valid_o[i]) begin
          ent_d[ridx[i]].vld = 1'b0;
          ent_d[ridx[i]].cmp = 1'b0;
        end
      end
      head_d  = head_q + r[IDXW-1:0];
      count_d = count_q - r;
      if (!disp_stall_o) begin
        for (int i = 0; i < N; i++) begin
          if (disp_valid_i[i]) begin
            ent_d[disp_rob_idx_o[i]] = '{vld: 1'b1, cmp: 1'b0, mp: 1'b0, tkn: 1'b0, tgt: '0,
                                         pc: disp_pc_i[i], ard: disp_arch_rd_i[i],
                                         prd: disp_phys_rd_i[i]};
          end
        end
        tail_d  = tail_q + k[IDXW-1:0];
        count_d = count_q + k - r;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < ROB_SZ; e++) ent_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_tracker.sv
// Directed bench for rob_tracker: per-cycle vector table plus fill/stall and wrap-around sequences.

module tb_rob_tracker;
  localparam int N = 3, IDXW = 5, PRW = 6, XLEN = 32;

  logic                   clk, rst_n;
  logic [N-1:0]           disp_valid;
  logic [N-1:0][XLEN-1:0] disp_pc;
  logic [N-1:0][4:0]      disp_arch_rd;
  logic [N-1:0][PRW-1:0]  disp_phys_rd;
  logic [N-1:0][IDXW-1:0] disp_rob_idx;
  logic                   disp_stall;
  logic [IDXW:0]          free_slots;
  logic [N-1:0]           cmp_valid, cmp_mp, cmp_tk;
  logic [N-1:0][IDXW-1:0] cmp_idx;
  logic [N-1:0][XLEN-1:0] cmp_tgt;
  logic [N-1:0]           retire_valid;
  logic [N-1:0][4:0]      retire_arch_rd;
  logic [N-1:0][PRW-1:0]  retire_phys_rd;
  logic [N-1:0][XLEN-1:0] retire_pc;
  logic                   flush_valid;
  logic [XLEN-1:0]        flush_target;

  int n_tests = 0;
  int n_fail  = 0;

  rob_tracker #(.N(N), .ROB_SZ(32), .PRW(PRW), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .disp_valid_i(disp_valid), .disp_pc_i(disp_pc), .disp_arch_rd_i(disp_arch_rd),
    .disp_phys_rd_i(disp_phys_rd), .disp_rob_idx_o(disp_rob_idx), .disp_stall_o(disp_stall),
    .free_slots_o(free_slots), .cmp_valid_i(cmp_valid), .cmp_idx_i(cmp_idx),
    .cmp_mispredict_i(cmp_mp), .cmp_branch_taken_i(cmp_tk), .cmp_branch_target_i(cmp_tgt),
    .retire_valid_o(retire_valid), .retire_arch_rd_o(retire_arch_rd),
    .retire_phys_rd_o(retire_phys_rd), .retire_pc_o(retire_pc),
    .flush_valid_o(flush_valid), .flush_target_o(flush_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [2:0]  dv;
    logic [31:0] pc;
    logic [2:0]  cv;
    logic [14:0] cidx;
    logic [2:0]  cmp_mp;
    logic [2:0]  ctk;
    logic [31:0] ctgt;
    logic [14:0] eidx;
    logic        est;
    logic [5:0]  efree;
    logic [2:0]  eret;
    logic        efl;
    logic [31:0] eftgt;
    logic [31:0] epc0;
    logic [5:0]  eprd0;
  } vec_t;

  vec_t tv [19];

  function automatic logic [14:0] ix(input int a2, input int a1, input int a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    disp_valid = '0;
    cmp_valid  = '0;
    cmp_idx    = '0;
    cmp_mp     = '0;
    cmp_tk     = '0;
    cmp_tgt    = '0;
  endtask

  task automatic set_pc(input logic [31:0] base);
    for (int l = 0; l < N; l++) begin
      disp_pc[l]      = base + 32'(4 * l);
      disp_arch_rd[l] = 5'(l + 1);
      disp_phys_rd[l] = 6'(10 + l);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    set_pc(32'h0);
    #2;
    chk("rst_free", 64'(free_slots), 64'd32);
    chk("rst_stall", 64'(disp_stall), 64'd0);
    chk("rst_ret", 64'(retire_valid), 64'd0);
    chk("rst_flush", 64'(flush_valid), 64'd0);
    chk("rst_ftgt", 64'(flush_target), 64'd0);
    chk("rst_idx", 64'(disp_rob_idx), 64'd0);

    //         rst   dv      pc        cv      cidx         mp      tk      tgt        eidx         st    free   ret     fl    ftgt       pc0        prd0
    tv[0]  = '{1'b1, 3'b111, 32'h100, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(2,1,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[1]  = '{1'b0, 3'b000, 32'h0,   3'b001, ix(0,0,1), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd29, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[2]  = '{1'b0, 3'b000, 32'h0,   3'b001, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd29, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[3]  = '{1'b0, 3'b000, 32'h0,   3'b001, ix(0,0,2), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd29, 3'b011, 1'b0, 32'h0,    32'h100, 6'd10};
    tv[4]  = '{1'b0, 3'b000, 32'h0,   3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd31, 3'b001, 1'b0, 32'h0,    32'h108, 6'd12};
    tv[5]  = '{1'b0, 3'b000, 32'h0,   3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[6]  = '{1'b1, 3'b111, 32'h300, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(2,1,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[7]  = '{1'b0, 3'b000, 32'h0,   3'b111, ix(2,1,0), 3'b010, 3'b010, 32'h1000, ix(0,0,0), 1'b0, 6'd29, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[8]  = '{1'b0, 3'b111, 32'h300, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(5,4,3), 1'b1, 6'd29, 3'b011, 1'b1, 32'h1000, 32'h300, 6'd10};
    tv[9]  = '{1'b0, 3'b001, 32'h200, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[10] = '{1'b0, 3'b000, 32'h0,   3'b001, ix(0,0,0), 3'b001, 3'b000, 32'h999,  ix(0,0,0), 1'b0, 6'd31, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[11] = '{1'b0, 3'b000, 32'h0,   3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b1, 6'd31, 3'b001, 1'b1, 32'h204,  32'h200, 6'd10};
    tv[12] = '{1'b0, 3'b111, 32'h400, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(2,1,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[13] = '{1'b0, 3'b111, 32'h500, 3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(5,4,3), 1'b0, 6'd29, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[14] = '{1'b0, 3'b000, 32'h0,   3'b101, ix(5,0,5), 3'b100, 3'b100, 32'h5555, ix(0,0,0), 1'b0, 6'd26, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[15] = '{1'b0, 3'b000, 32'h0,   3'b111, ix(2,1,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd26, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};
    tv[16] = '{1'b0, 3'b000, 32'h0,   3'b011, ix(0,4,3), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd26, 3'b111, 1'b0, 32'h0,    32'h400, 6'd10};
    tv[17] = '{1'b0, 3'b000, 32'h0,   3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b1, 6'd29, 3'b111, 1'b1, 32'h5555, 32'h500, 6'd10};
    tv[18] = '{1'b0, 3'b000, 32'h0,   3'b000, ix(0,0,0), 3'b000, 3'b000, 32'h0,    ix(0,0,0), 1'b0, 6'd32, 3'b000, 1'b0, 32'h0,    32'h0,   6'd0};

    for (int v = 0; v < 19; v++) begin
      if (tv[v].rst) do_reset();
      disp_valid = tv[v].dv;
      set_pc(tv[v].pc);
      cmp_valid = tv[v].cv;
      cmp_idx   = tv[v].cidx;
      cmp_mp    = tv[v].cmp_mp;
      cmp_tk    = tv[v].ctk;
      for (int l = 0; l < N; l++) cmp_tgt[l] = tv[v].ctgt;
      #1;
      chk($sformatf("v%0d_idx", v), 64'(disp_rob_idx), 64'(tv[v].eidx));
      chk($sformatf("v%0d_stall", v), 64'(disp_stall), 64'(tv[v].est));
      chk($sformatf("v%0d_free", v), 64'(free_slots), 64'(tv[v].efree));
      chk($sformatf("v%0d_ret", v), 64'(retire_valid), 64'(tv[v].eret));
      chk($sformatf("v%0d_flush", v), 64'(flush_valid), 64'(tv[v].efl));
      if (tv[v].efl) chk($sformatf("v%0d_ftgt", v), 64'(flush_target), 64'(tv[v].eftgt));
      if (tv[v].eret[0]) begin
        chk($sformatf("v%0d_rpc0", v), 64'(retire_pc[0]), 64'(tv[v].epc0));
        chk($sformatf("v%0d_rprd0", v), 64'(retire_phys_rd[0]), 64'(tv[v].eprd0));
      end
      step();
    end

    // Fill to 31, then all-or-nothing stall and the last free slot
    clear_inputs();
    do_reset();
    set_pc(32'h800);
    for (int c = 0; c < 10; c++) begin
      disp_valid = 3'b111;
      step();
    end
    disp_valid = 3'b001;
    step();
    disp_valid = 3'b000;
    #1;
    chk("fill_free31", 64'(free_slots), 64'd1);
    disp_valid = 3'b011;
    #1;
    chk("fill_stall2", 64'(disp_stall), 64'd1);
    step();
    disp_valid = 3'b000;
    #1;
    chk("fill_noalloc", 64'(free_slots), 64'd1);
    disp_valid = 3'b100;
    #1;
    chk("fill_stall1", 64'(disp_stall), 64'd0);
    chk("fill_idx31", 64'(disp_rob_idx[2]), 64'd31);
    step();
    disp_valid = 3'b000;
    #1;
    chk("full_free0", 64'(free_slots), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_free", 64'(free_slots), 64'd32);
    chk("midrst_flush", 64'(flush_valid), 64'd0);

    // Wrap: move head/tail to 30, then allocate across the boundary
    clear_inputs();
    do_reset();
    set_pc(32'h600);
    for (int c = 0; c < 10; c++) begin
      disp_valid = 3'b111;
      step();
    end
    disp_valid = 3'b000;
    for (int c = 0; c < 10; c++) begin
      cmp_valid = 3'b111;
      cmp_idx   = ix(3*c+2, 3*c+1, 3*c);
      step();
    end
    cmp_valid = 3'b000;
    for (int c = 0; c < 20 && free_slots != 6'd32; c++) step();
    #1;
    chk("wrap_drained", 64'(free_slots), 64'd32);
    set_pc(32'h700);
    disp_valid = 3'b111;
    #1;
    chk("wrap_idx", 64'(disp_rob_idx), 64'(ix(0, 31, 30)));
    step();
    disp_valid = 3'b000;
    cmp_valid  = 3'b111;
    cmp_idx    = ix(0, 31, 30);
    #1;
    chk("wrap_ret0", 64'(retire_valid), 64'd0);
    step();
    cmp_valid = 3'b000;
    #1;
    chk("wrap_ret", 64'(retire_valid), 64'b111);
    chk("wrap_pc0", 64'(retire_pc[0]), 64'h700);
    chk("wrap_pc1", 64'(retire_pc[1]), 64'h704);
    chk("wrap_pc2", 64'(retire_pc[2]), 64'h708);
    chk("wrap_ard2", 64'(retire_arch_rd[2]), 64'd3);
    chk("wrap_flush", 64'(flush_valid), 64'd0);
    step();
    chk("wrap_free", 64'(free_slots), 64'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_tracker.md
Name: rob_tracker

Overview:
- Reorder buffer that receives per-lane completion updates from the complete stage and marks entries done.
- Allocates entries in program order at dispatch and retires up to N oldest completed entries per cycle.
- On retiring a mispredicted branch, raises a one-cycle flush with the redirect PC and clears all younger state.
- Sits between dispatch (allocation), the complete stage (updates) and retire/architectural map (commit).

Parameters:
N, `N (3), superscalar width for dispatch, complete and retire lanes
ROB_SZ, 32, entry count; power of two, at least 2*N
IDXW, $clog2(ROB_SZ), entry index width
PRW, 6, physical register tag width
XLEN, 32, PC/target width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
disp_valid  in  N  per-lane allocation request, any bit pattern
disp_pc  in  N*XLEN  instruction PC per lane
disp_arch_rd  in  N*5  architectural destination per lane
disp_phys_rd  in  N*PRW  physical destination per lane
disp_rob_idx  out  N*IDXW  index assigned to each requesting lane (combinational)
disp_stall  out  1  request count exceeds free_slots; nothing allocated
free_slots  out  IDXW+1  ROB_SZ minus occupancy (registered state)
cmp_valid  in  N  completion update valid per lane
cmp_idx  in  N*IDXW  entry being completed
cmp_mispredict  in  N  branch resolved mispredicted
cmp_branch_taken  in  N  resolved direction
cmp_branch_target  in  N*XLEN  resolved taken target
retire_valid  out  N  lane retires this cycle; contiguous from lane 0
retire_arch_rd  out  N*5  committed architectural destination
retire_phys_rd  out  N*PRW  committed physical destination
retire_pc  out  N*XLEN  committed PC
flush_valid  out  1  mispredict retired this cycle
flush_target  out  XLEN  redirect PC

Behaviour:
- State: head, tail (IDXW wrap), count (IDXW+1), per-entry valid/complete/mispredict/taken/target/pc/arch_rd/phys_rd.
- Reset (reset=0, async): head=tail=count=0; all valid/complete cleared; retire_valid=0, flush_valid=0, flush_target=0, disp_stall=0, free_slots=ROB_SZ, disp_rob_idx=0.
- Dispatch: k=popcount(disp_valid). If k<=free_slots, set lanes receive tail, tail+1, ... in ascending lane order, mod ROB_SZ. Entries are written at the edge with valid=1, complete=0, and tail+=k. If k>free_slots, disp_stall=1 and nothing is allocated (all-or-nothing).
- free_slots uses the current count only. Same-cycle retirements are not credited (conservative). Full: count==ROB_SZ gives free_slots=0.
- Completion: a cmp lane with cmp_valid=1 targeting a valid entry sets complete, mispredict, taken and target at the edge. Updates to invalid entries are ignored. Duplicate idx in one cycle: the highest lane wins.
- Completion-to-retire latency: at least 1 cycle. An entry completed at edge t can retire in the cycle after t.
- Retire (combinational from registered state): lane i is valid iff entries head..head+i are all valid and complete, and none of head..head+i-1 is mispredicted. At the edge, head+=r and count-=r, and retired entries are invalidated.
- Mispredict: if a retiring entry has mispredict=1, it is the last retiring lane and flush_valid=1 that cycle. flush_target=target if taken, else pc+4.
- Flush edge: all entries invalidated; head=tail=count=0. Dispatch and completion in the flush cycle are dropped, and disp_stall is forced to 1.
- Simultaneous dispatch + retire (no flush): both are applied; count'=count+k-r.
- Wrap-around: all index arithmetic is modulo ROB_SZ.
- Reset asserted mid-operation clears everything immediately; no flush is signalled.

Test Plan:
- Reset, then dispatch 3 lanes disp_valid=3'b111 → disp_rob_idx=0,1,2; next cycle free_slots=29.
- Complete idx 1 only → retire_valid=000. Then complete idx 0 → next cycle retire_valid=011. Then complete 2 → retire_valid=001, free_slots=32.
- Fill to 31 entries, request 2 lanes → disp_stall=1, no allocation, free_slots stays 1. Request 1 lane → idx 31 assigned, free_slots=0.
- Wrap: head=tail=30, dispatch 3 → idx 30, 31, 0. Complete all → all 3 retire in order.
- Entries 0..2 complete, idx 1 mispredict taken target 0x0000_1000 → retire_valid=011, flush_valid=1, flush_target=0x1000. Next cycle free_slots=32. A same-cycle dispatch is dropped.
- Not-taken mispredict at pc 0x200 → flush_target=0x204. Duplicate cmp_idx=5 on lanes 0 and 2 → lane 2 fields stored.
